// File: rtl/uart_rx_sipo_param.sv
// uart_rx_sipo_param: oversampled UART receive deserialiser with parity/stop checks.
// Ports: baud_clk, reset_n (async, active-low), rx_serial, rx_ready in;
//        rx_data[DATA_BITS], rx_valid, parity_err, frame_err, overrun, busy out.
// Option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_sipo_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 baud_clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned   CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    // Start decision one cycle later so the 3-sample window straddles the centre;
    // later bits keep the same period, so their window stays centred too.
    localparam logic [CW-1:0] CNT_START = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] CNT_START = CW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t               state_q, state_d;
    logic                 sync_q, rxs_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 commit;
    logic                 bit_v;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) hist_q <= 2'b11;
        else          hist_q <= {hist_q[0], rxs_q};
    end

    assign bit_v = (hist_q[1] & hist_q[0]) |
                   (hist_q[1] & rxs_q) |
                   (hist_q[0] & rxs_q);
`else
    assign bit_v = rxs_q;
`endif

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync_q       <= 1'b1;
            rxs_q        <= 1'b1;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= rx_serial;
            rxs_q        <= sync_q;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = bit_v ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    shift_d = {bit_v, shift_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + 4'd1;
                    if (bcnt_q == BIT_LAST) begin
                        bcnt_d  = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    perr_d  = (^shift_q) ^ bit_v ^ PARITY_ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    if (!bit_v) ferr_d = 1'b1;
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == STOP_LAST) begin
                        commit = 1'b1;
                        bcnt_d = '0;
                        // A low final stop means break/stuck line: wait for idle.
                        state_d = bit_v ? IDLE : BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = PARITY_EN & perr_q;
                frame_err_d  = ferr_q | ~bit_v;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo_param.sv
// tb_uart_rx_sipo_param: directed bench for uart_rx_sipo_param.
// Instance 0 is 8N1, instance 1 is 8E1; both OVERSAMPLE=16.
module tb_uart_rx_sipo_param;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       ser [2];
    logic       rdy [2];
    logic [7:0] dat [2];
    logic       val [2];
    logic       pe  [2];
    logic       fe  [2];
    logic       ovr [2];
    logic       bsy [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ovr_cnt [2];
    logic ovr_prev [2];
    int   w_cyc;
    logic [9:0] w_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_sipo_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0),
        .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) u_n (
        .baud_clk(clk), .reset_n(reset_n), .rx_serial(ser[0]),
        .rx_ready(rdy[0]), .rx_data(dat[0]), .rx_valid(val[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]),
        .busy(bsy[0])
    );

    uart_rx_sipo_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b1),
        .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) u_e (
        .baud_clk(clk), .reset_n(reset_n), .rx_serial(ser[1]),
        .rx_ready(rdy[1]), .rx_data(dat[1]), .rx_valid(val[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]),
        .busy(bsy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Compare process: every presented word must match the oldest expected frame.
    initial begin
        ovr_cnt[0] = 0; ovr_cnt[1] = 0;
        ovr_prev[0] = 1'b0; ovr_prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ovr[i] === 1'b1) begin
                    ovr_cnt[i]++;
                    chk("overrun pulse width", 32'(ovr_prev[i]), 32'd0);
                end
                ovr_prev[i] = ovr[i];
                if (val[i] === 1'b1) begin
                    if (qsize(i) == 0) begin
                        chk("spurious valid", 32'd1, 32'd0);
                    end else begin
                        chk("word", 32'({dat[i], pe[i], fe[i]}), 32'(qhead(i)));
                        if (rdy[i]) qpop(i);
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input logic v, input int n, input int spike);
        for (int j = 0; j < n; j++) begin
            ser[i] = (j == spike) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input logic pflip,
                              input logic stopv, input bit push, input int spike);
        logic pbit;
        exp_t e;
        pbit = (^d) ^ pflip;
        drive(i, 1'b0, 16, -1);
        for (int b = 0; b < 8; b++) drive(i, d[b], 16, spike);
        if (i == 1) drive(i, pbit, 16, -1);
        e.d  = d;
        // Even parity: total count of ones over data+parity must be even.
        e.pe = (i == 1) ? (^{d, pbit}) : 1'b0;
        e.fe = ~stopv;
        if (push) qpush(i, e);
        drive(i, stopv, 16, -1);
    endtask

    task automatic xfer(input int i, input logic [7:0] d, input logic pflip,
                        input logic stopv, input int spike);
        fork
            send_frame(i, d, pflip, stopv, 1'b1, spike);
            begin
                w_cyc  = -1;
                w_word = '0;
                for (int c = 1; c <= 400; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (val[i] === 1'b1) begin
                        w_cyc  = c;
                        w_word = {dat[i], pe[i], fe[i]};
                        break;
                    end
                end
            end
        join
        chk("frame seen", 32'(w_cyc > 0), 32'd1);
    endtask

    task automatic chk_reset(input int i);
        chk("reset rx_valid", 32'(val[i]), 32'd0);
        chk("reset busy", 32'(bsy[i]), 32'd0);
        chk("reset rx_data", 32'(dat[i]), 32'd0);
        chk("reset parity_err", 32'(pe[i]), 32'd0);
        chk("reset frame_err", 32'(fe[i]), 32'd0);
        chk("reset overrun", 32'(ovr[i]), 32'd0);
    endtask

    initial begin
        int ocnt;
        reset_n = 1'b0;
        ser[0] = 1'b1; ser[1] = 1'b1;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(0, 1'b1, 6, -1);

        // 8N1 0xA5: latency 155 +/- 1 from the start edge.
        xfer(0, 8'hA5, 1'b0, 1'b1, -1);
        chk("8N1 latency", 32'(w_cyc >= 154 && w_cyc <= 156), 32'd1);
        chk("8N1 word", 32'(w_word), 32'({8'hA5, 1'b0, 1'b0}));
        drive(0, 1'b1, 8, -1);

        // 8E1 0x3C: good parity bit 0, then bad parity bit 1.
        xfer(1, 8'h3C, 1'b0, 1'b1, -1);
        chk("8E1 good parity", 32'(w_word), 32'({8'h3C, 1'b0, 1'b0}));
        drive(1, 1'b1, 8, -1);
        xfer(1, 8'h3C, 1'b1, 1'b1, -1);
        chk("8E1 bad parity", 32'(w_word), 32'({8'h3C, 1'b1, 1'b0}));
        drive(1, 1'b1, 8, -1);

        // 4-cycle low glitch: false start rejected at the centre check.
        drive(1, 1'b0, 4, -1);
        ser[1] = 1'b1;
        @(negedge clk);
        chk("glitch busy high", 32'(bsy[1]), 32'd1);
        drive(1, 1'b1, 12, -1);
        @(negedge clk);
        chk("glitch back idle", 32'(bsy[1]), 32'd0);
        drive(1, 1'b1, 20, -1);

        // Stop bit low, line held low: framing error, no restart until high.
        xfer(1, 8'h55, 1'b0, 1'b0, -1);
        chk("frame err word", 32'(w_word), 32'({8'h55, 1'b0, 1'b1}));
        drive(1, 1'b0, 40, -1);
        @(negedge clk);
        chk("break busy", 32'(bsy[1]), 32'd1);
        drive(1, 1'b1, 4, -1);
        @(negedge clk);
        chk("break released", 32'(bsy[1]), 32'd0);
        drive(1, 1'b1, 10, -1);

        // Overrun: consumer stalled across two frames.
        rdy[1] = 1'b0;
        ocnt = ovr_cnt[1];
        xfer(1, 8'h11, 1'b0, 1'b1, -1);
        chk("overrun first word", 32'(w_word), 32'({8'h11, 1'b0, 1'b0}));
        send_frame(1, 8'h22, 1'b0, 1'b1, 1'b0, -1);
        drive(1, 1'b1, 4, -1);
        @(negedge clk);
        chk("overrun pulses", 32'(ovr_cnt[1] - ocnt), 32'd1);
        chk("overrun held valid", 32'(val[1]), 32'd1);
        chk("overrun held data", 32'(dat[1]), 32'h11);
        @(posedge clk);
        #1 rdy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("valid drops after accept", 32'(val[1]), 32'd0);
        drive(1, 1'b1, 6, -1);

        // Reset in the middle of DATA, then a clean frame.
        drive(1, 1'b0, 16, -1);
        drive(1, 1'b1, 30, -1);
        @(negedge clk);
        chk("mid-frame busy", 32'(bsy[1]), 32'd1);
        reset_n = 1'b0;
        ser[1] = 1'b1;
        #1;
        chk_reset(1);
        chk_reset(0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(1, 1'b1, 6, -1);
        xfer(1, 8'h0F, 1'b0, 1'b1, -1);
        chk("after reset word", 32'(w_word), 32'({8'h0F, 1'b0, 1'b0}));
        drive(1, 1'b1, 8, -1);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inverted spike at every data-bit centre is voted out.
        xfer(0, 8'hA5, 1'b0, 1'b1, 8);
        chk("majority spike", 32'(w_word), 32'({8'hA5, 1'b0, 1'b0}));
        drive(0, 1'b1, 8, -1);
`endif

        drive(1, 1'b1, 20, -1);
        chk("all frames delivered", 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_sipo_param.md
Name: uart_rx_sipo_param

Overview:
- Parametrised successor to the fixed 11-bit frame capture stage of the UART receiver.
- Deserialises an oversampled asynchronous serial line into a word of configurable width, with configurable parity and stop-bit count.
- Rejects false start bits and reports parity, framing and overrun errors.
- Sits between the baud/sampling clock generator and the consumer (deframe/FIFO), which it feeds through a valid/ready handshake.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- OVERSAMPLE, 16, baud_clk cycles per bit; power of two, 8..32.
- PARITY_EN, 1, 1 = one parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 1 = odd parity; 0 = even parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits checked; 1 or 2.

Ports:
- baud_clk  in  1  oversampling clock, OVERSAMPLE x bit rate
- reset_n  in  1  reset, asynchronous, active-low
- rx_serial  in  1  asynchronous serial line; idles high
- rx_ready  in  1  consumer accepts the word when high with rx_valid
- rx_data  out  DATA_BITS  received word
- rx_valid  out  1  rx_data and error flags valid
- parity_err  out  1  parity mismatch on the presented word
- frame_err  out  1  one or more stop bits sampled low on the presented word
- overrun  out  1  one-cycle pulse: a completed frame was dropped
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE, both synchroniser flops 1, counters 0, rx_data 0, rx_valid 0, all error flags 0, busy 0.
- Synchronisation: rx_serial passes through a 2-flop synchroniser. All decisions below use the synchronised value rxs.
- Counters: sample counter cnt is log2(OVERSAMPLE) bits. Bit counter bcnt is 4 bits.

State machine:
- IDLE: when rxs=0, go to START with cnt=0.
- START: increment cnt. At cnt=OVERSAMPLE/2-1 (bit centre), sample rxs.
  - rxs=1: false start; return to IDLE with no flags and no output.
  - rxs=0: cnt=0, bcnt=0, go to DATA.
- DATA: at cnt=OVERSAMPLE-1, sample rxs into shift-register MSB and shift right (LSB-first assembly), bcnt+1, cnt=0.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: at cnt=OVERSAMPLE-1, sample. Compute perr = XOR(data, sampled bit) XOR PARITY_ODD.
- STOP: sample STOP_BITS bits, each at cnt=OVERSAMPLE-1. Any low sample sets ferr.
  - After the last stop sample, perform the commit below.
  - Then go to IDLE if the last sample was 1, else go to BRK.
- BRK: wait until rxs=1, then go to IDLE. This covers a break or a line stuck low, so a low line never re-triggers START.
- Commit:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data, parity_err, frame_err; set rx_valid=1.
  - Otherwise: the new frame is discarded, the old word is held, and overrun pulses for one cycle.
- Handshake:
  - rx_valid clears on the cycle after rx_valid and rx_ready are both high, unless a commit occurs in that same cycle.
  - rx_data and the error flags are stable while rx_valid is high.
- Back-to-back frames: the return to IDLE at the stop-bit centre allows a start bit that immediately follows a stop bit to be caught.
- Reset mid-frame: immediately returns to the reset state. No partial word is presented.
- Word format: PARITY_EN=0 forces parity_err=0. Unused upper rx_data bits do not exist; the width is exactly DATA_BITS.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Every bit decision uses a 2-of-3 majority of rxs at cnt=centre-1, centre and centre+1, where centre is OVERSAMPLE/2-1 for the start bit and OVERSAMPLE-1 otherwise.
  - The state advance happens at centre+1.
  - Adds 1 cycle to all decision points.
- Undefined: single sample at the centre, as described above.

Test Plan:
- 8N1 (PARITY_EN=0), OVERSAMPLE=16, send 0xA5, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5 and no errors. It asserts 155±1 baud_clk cycles after the start falling edge.
- 8E1, send 0x3C with correct parity bit 0, then 0x3C with parity bit 1 -> first frame parity_err=0; second frame parity_err=1 with rx_data=0x3C.
- Low glitch of 4 baud_clk cycles on idle line -> busy rises, returns to IDLE at the centre check, rx_valid never asserts.
- Frame 0x55 with stop bit driven 0, line held low 40 cycles, then high -> frame_err=1 and rx_valid=1. No second frame is started until rxs=1.
- rx_ready=0 while two frames 0x11 and 0x22 arrive -> rx_data stays 0x11 and overrun pulses 1 cycle. Then with rx_ready=1, rx_valid drops next cycle.
- Assert reset_n low mid-DATA, release, then send 0x0F -> no output from the aborted frame; 0x0F is received correctly.
- With UART_RX_MAJORITY_EN defined: a 1-cycle inverted spike at each data-bit centre -> data is still 0xA5.
